// File: rtl/ps2_pkg.sv
// Shared codes, frame FSM state encoding and the key event record for the PS/2 receiver.
package ps2_pkg;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;
    localparam logic [7:0] ERR_CODE0  = 8'h00;
    localparam logic [7:0] ERR_CODE1  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_event_t;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

    function automatic logic is_filler(input logic [7:0] code);
        return (code == ERR_CODE0) || (code == ERR_CODE1);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: pin synchronisers, clock glitch filter, frame FSM,
// odd-parity check and inter-edge timeout. Outputs are single-cycle pulses.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_done,
    output logic [7:0] data_byte,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic                  clk_sync_p0;
    logic                  clk_sync_p1;
    logic                  data_sync_p0;
    logic                  data_sync_p1;
    logic [FILTER_LEN-1:0] clk_hist;
    logic                  filt_clk;
    logic                  fall;
    logic                  timeout;
    frame_state_t          state;
    logic [2:0]            bit_cnt;
    logic [7:0]            shift;
    logic                  parity_ok;
    logic [TW-1:0]         idle_cnt;

    // Synchroniser stage and filter stage
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_sync_p0  <= 1'b1;
            clk_sync_p1  <= 1'b1;
            data_sync_p0 <= 1'b1;
            data_sync_p1 <= 1'b1;
            clk_hist     <= '1;
            filt_clk     <= 1'b1;
        end else begin
            clk_sync_p0  <= ps2_clk;
            clk_sync_p1  <= clk_sync_p0;
            data_sync_p0 <= ps2_data;
            data_sync_p1 <= data_sync_p0;
            clk_hist     <= {clk_hist[FILTER_LEN-2:0], clk_sync_p1};
            if (clk_hist == '0) begin
                filt_clk <= 1'b0;
            end else if (&clk_hist) begin
                filt_clk <= 1'b1;
            end
        end
    end

    // The edge is flagged in the cycle the filtered clock is about to drop.
    assign fall    = filt_clk && (clk_hist == '0);
    assign timeout = (state != ST_IDLE) && !fall &&
                     (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Frame FSM stage
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            parity_ok  <= 1'b0;
            idle_cnt   <= '0;
            byte_done  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_done  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (state == ST_IDLE || fall) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TW'(1);
            end

            if (timeout) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!data_sync_p1) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_ok <= odd_parity_ok(shift, data_sync_p1);
                        state     <= ST_STOP;
                    end
                    ST_STOP: begin
                        byte_done  <= data_sync_p1 && parity_ok;
                        frame_err  <= !data_sync_p1;
                        parity_err <= !parity_ok;
                        state      <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Data path: shift register and output byte carry no reset.
    always_ff @(posedge clk) begin
        if (fall && state == ST_DATA) begin
            shift <= {data_sync_p1, shift[7:1]};
        end
        if (fall && state == ST_STOP) begin
            data_byte <= shift;
        end
    end

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver top: prefix decoder, event FIFO, interrupt pulse and
// sticky error flags around the frame deserialiser.
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int FIFO_DEPTH     = 8,
    parameter int INTR_CYCLES    = 7,
    parameter int REPORT_RELEASE = 1
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       PS2CLK,
    input  logic       PS2DATA,
    input  logic       POP,
    input  logic       CLR_ERR,
    output logic       INTRPT,
    output logic       VALID,
    output logic [7:0] SCANCODE,
    output logic       EXTENDED,
    output logic       RELEASE,
    output logic       OVERFLOW,
    output logic       PARITY_ERR,
    output logic       FRAME_ERR
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int IW = (INTR_CYCLES < 1) ? 1 : $clog2(INTR_CYCLES + 1);

    logic          byte_done;
    logic [7:0]    data_byte;
    logic          parity_pulse;
    logic          frame_pulse;
    logic          ext_pend;
    logic          rel_pend;
    logic          push_req;
    key_event_t    ev;
    key_event_t    mem [FIFO_DEPTH];
    key_event_t    head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          pop_ok;
    logic          push_ok;
    logic [IW-1:0] intr_cnt;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk       (CLK),
        .reset_n   (RESET_N),
        .ps2_clk   (PS2CLK),
        .ps2_data  (PS2DATA),
        .byte_done (byte_done),
        .data_byte (data_byte),
        .parity_err(parity_pulse),
        .frame_err (frame_pulse)
    );

    // Decoder stage: prefixes accumulate, filler bytes are transparent
    always_comb begin
        push_req = 1'b0;
        ev       = '0;
        if (byte_done && data_byte != EXT_CODE && data_byte != BREAK_CODE &&
            !is_filler(data_byte)) begin
            ev.ext   = ext_pend;
            ev.rel   = rel_pend;
            ev.code  = data_byte;
            push_req = !(rel_pend && REPORT_RELEASE == 0);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ext_pend <= 1'b0;
            rel_pend <= 1'b0;
        end else if (byte_done) begin
            if (data_byte == EXT_CODE) begin
                ext_pend <= 1'b1;
            end else if (data_byte == BREAK_CODE) begin
                rel_pend <= 1'b1;
            end else if (!is_filler(data_byte)) begin
                ext_pend <= 1'b0;
                rel_pend <= 1'b0;
            end
        end
    end

    // FIFO stage: the pop is resolved before the push so a full FIFO can accept
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = POP && !empty;
    assign push_ok = push_req && (!full || pop_ok);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= ev;
        end
    end

    assign head     = mem[rd_ptr[AW-1:0]];
    assign VALID    = !empty;
    assign SCANCODE = VALID ? head.code : 8'h00;
    assign EXTENDED = VALID && head.ext;
    assign RELEASE  = VALID && head.rel;

    // Interrupt and sticky-flag stage: a fresh error outranks a clear
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            intr_cnt   <= '0;
            OVERFLOW   <= 1'b0;
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            if (push_ok) begin
                intr_cnt <= IW'(INTR_CYCLES);
            end else if (intr_cnt != '0) begin
                intr_cnt <= intr_cnt - IW'(1);
            end

            if (push_req && full && !pop_ok) begin
                OVERFLOW <= 1'b1;
            end else if (CLR_ERR) begin
                OVERFLOW <= 1'b0;
            end

            if (parity_pulse) begin
                PARITY_ERR <= 1'b1;
            end else if (CLR_ERR) begin
                PARITY_ERR <= 1'b0;
            end

            if (frame_pulse) begin
                FRAME_ERR <= 1'b1;
            end else if (CLR_ERR) begin
                FRAME_ERR <= 1'b0;
            end
        end
    end

    assign INTRPT = (intr_cnt != '0);

endmodule

// File: doc/ps2_key_event_rx.md
# ps2_key_event_rx

Parametrised PS/2 keyboard receiver that runs directly on the 100 MHz system clock with no clock divider. It deserialises and checks each frame, folds E0/F0 prefixes into single key events with extended/release flags, and buffers events in a FIFO. It sits between the PS2CLK/PS2DATA pins and the CPU interrupt/input-port logic. Buffered events are announced with an interrupt pulse and removed by an explicit pop.

## Interface
- FILTER_LEN, 8: consecutive equal synchronised PS2CLK samples required to change the filtered clock.
- TIMEOUT_CYCLES, 200000: maximum idle cycles between falling edges inside a frame (2 ms at 100 MHz).
- FIFO_DEPTH, 8: number of event entries; must be a power of 2 and at least 2.
- INTR_CYCLES, 7: INTRPT high time, in cycles.
- REPORT_RELEASE, 1: 1 = push release events; 0 = decode release events but drop them.
- CLK  in  1  100 MHz system clock.
- RESET_N  in  1  reset, synchronous, active-low.
- PS2CLK  in  1  raw PS/2 clock.
- PS2DATA  in  1  raw PS/2 data.
- POP  in  1  remove the FIFO head; ignored when VALID=0.
- CLR_ERR  in  1  clear the sticky error flags.
- INTRPT  out  1  event-pushed pulse.
- VALID  out  1  FIFO not empty.
- SCANCODE  out  8  head event code.
- EXTENDED  out  1  head event was E0-prefixed.
- RELEASE  out  1  head event was F0-prefixed.
- OVERFLOW  out  1  sticky: an event was dropped because the FIFO was full.
- PARITY_ERR  out  1  sticky: a frame failed the odd-parity check.
- FRAME_ERR  out  1  sticky: bad start bit, bad stop bit, or timeout.

## Operation
- **Input conditioning.** PS2CLK and PS2DATA each pass through a 2-flop synchroniser. The filtered clock f becomes 1 or 0 only when the last FILTER_LEN synchronised PS2CLK samples are all 1 or all 0. A falling edge is f going 1→0.
- **Frame FSM states.** IDLE, DATA, PARITY, STOP. Synchronised PS2DATA is sampled on each falling edge.
  - IDLE: on a falling edge, data=0 → DATA with bit count 0; data=1 → set FRAME_ERR, stay in IDLE.
  - DATA: 8 bits, LSB first, then → PARITY.
  - PARITY: the 8 data bits plus the parity bit must contain an odd number of ones; the result is recorded; → STOP.
  - STOP: data=1 and parity good → byte done. Stop bit=0 → set FRAME_ERR. Parity bad → set PARITY_ERR. Both flags are set if both faults occur. Always → IDLE.
  - In DATA, PARITY or STOP, TIMEOUT_CYCLES cycles with no falling edge → IDLE, set FRAME_ERR, partial byte discarded.
- **Decoder.** Holds ext_pend and rel_pend flags.
  - Byte E0 sets ext_pend; byte F0 sets rel_pend. Neither byte is pushed.
  - Bytes 00 and FF are discarded; they do not change the pending flags.
  - Any other byte forms the event {ext_pend, rel_pend, byte} and clears both flags.
  - If rel_pend=1 and REPORT_RELEASE=0, the event is not pushed.
- **FIFO.** 10-bit entries with a write and read pointer, log2(FIFO_DEPTH)+1 bits each, wrapping modulo 2·FIFO_DEPTH.
  - The head entry drives SCANCODE, EXTENDED and RELEASE; these outputs are 0 when empty.
  - A push into a full FIFO is dropped, sets OVERFLOW, and gives no INTRPT.
  - A push and a POP in the same cycle while full: both succeed, because the pop is evaluated first.
  - A push and a POP in the same cycle while empty: only the push takes effect.
- **Interrupt.** Each accepted push loads a counter with INTR_CYCLES; INTRPT = (counter≠0). A push during an active pulse reloads the counter, extending the pulse.
- **Errors.** Sticky flags clear on CLR_ERR. If CLR_ERR and a new error occur in the same cycle, the new error wins.

## Timing
- Reset values: all outputs 0, f=1, FSM in IDLE, pointers 0, pending flags 0, timeout counter 0. Reset mid-frame discards the partial byte and the pending prefixes.
- Edge E is the cycle in which the stop-bit falling edge is detected.
  - Byte to decoder at E+1.
  - Event written to the FIFO at E+2.
  - VALID, the head outputs and INTRPT are visible from E+2.
- Pin-to-edge delay is 2 synchroniser cycles plus FILTER_LEN cycles.
- POP sampled at cycle t: the next head entry (or VALID=0) is visible at t+1.
- INTRPT stays high for exactly INTR_CYCLES cycles after the last accepted push.

## Structure
- Package ps2_pkg holds:
  - localparams BREAK_CODE=8'hF0, EXT_CODE=8'hE0, ERR_CODE0=8'h00, ERR_CODE1=8'hFF;
  - the frame FSM state enum;
  - the packed event struct {ext, rel, code[7:0]}.
- Sub-module ps2_frame_rx contains the synchronisers, filter, frame FSM, parity check and timeout. Its outputs are byte_done, byte[7:0], parity_err and frame_err.
- The decoder, FIFO and interrupt logic live in the top module.

## Test plan
- Send frame 1C (parity 0, stop 1) → at E+2: VALID=1, SCANCODE=1C, EXTENDED=0, RELEASE=0, INTRPT high for 7 cycles. Then POP → VALID=0 on the next cycle.
- Send E0, F0, 75 → exactly one event {EXTENDED=1, RELEASE=1, SCANCODE=75} and exactly one INTRPT pulse. Repeat with REPORT_RELEASE=0 → no event, no pulse.
- Send frame 1C with parity bit 1 → no event, PARITY_ERR=1. Assert CLR_ERR → PARITY_ERR=0.
- Send 5 bits, then idle for 200000 cycles → FRAME_ERR=1. A following valid frame 1C is received correctly.
- With no POP, push 9 events into the 8-entry FIFO → OVERFLOW=1 and the 9th event is lost. Pop all 8 → codes come out in push order.
- Inject 3-cycle glitches on PS2CLK → no falling edge is detected and no state change occurs. Deassert RESET_N mid-frame → all outputs 0 and no event results.
